// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//   Time-multiplexed driver for eight active-low seven-segment digits.
//   A CPU write port fills a small register file (per-digit nibble / enable /
//   blink plus a control register). A prescaled scanner walks the eight digit
//   positions, pushing each one through a single shared glyph decoder and
//   latching the result into that digit's slice of the output register.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   wr_en      : write strobe, one write per asserted cycle
//   wr_addr    : 0-7 digit registers, 8 control register, 9-15 ignored
//   wr_data    : digit {blink[5], en[4], nibble[3:0]}; control {freeze[1], lzs[0]}
//   hex_out    : digit i segments at [7i+6:7i], active low, {g,f,e,d,c,b,a}
//   frame_done : one-cycle pulse after the scan tick that finishes digit 7
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic [55:0] hex_out,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    GLYPH_BLANK = 7'b1111111;

  // register file
  logic [3:0]  r_nib [8];
  logic [7:0]  r_en;
  logic [7:0]  r_blink;
  logic        r_lzs;
  logic        r_freeze;

  // scan state
  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic [55:0]   r_hex;
  logic          r_frame_done;

  logic       w_tick;
  logic       w_frame_end;
  logic       w_lz_run;
  logic       w_blank;
  logic [6:0] w_glyph;
  logic       w_unused;

  // Upper data bits carry nothing for either register type.
  assign w_unused = &{1'b0, wr_data[7:6]};

  function automatic logic [6:0] f_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // ---------------- register file ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_nib[i] <= 4'h0;
      r_en     <= 8'h00;
      r_blink  <= 8'h00;
      r_lzs    <= 1'b0;
      r_freeze <= 1'b0;
    end else if (wr_en) begin
      if (!wr_addr[3]) begin
        r_nib[wr_addr[2:0]]   <= wr_data[3:0];
        r_en[wr_addr[2:0]]    <= wr_data[4];
        r_blink[wr_addr[2:0]] <= wr_data[5];
      end else if (wr_addr == 4'd8) begin
        r_lzs    <= wr_data[0];
        r_freeze <= wr_data[1];
      end
    end
  end

  // ---------------- scan timing ----------------
  assign w_tick      = (r_presc == PRESC_MAX);
  assign w_frame_end = w_tick && (r_idx == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_idx         <= 3'd0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      if (w_frame_end) begin
        if (r_frame_cnt == FRAME_MAX) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- glyph resolution for the digit under scan ----------------
  // The leading-zero run holds while every enabled digit at or above the
  // current position carries nibble 0; disabled digits are transparent.
  always_comb begin
    w_lz_run = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if ((j >= int'(r_idx)) && r_en[j] && (r_nib[j] != 4'h0)) w_lz_run = 1'b0;
    end
  end

  assign w_blank = !r_en[r_idx]
                || (r_blink[r_idx] && r_blink_phase)
                || (r_lzs && (r_idx != 3'd0) && w_lz_run);

  assign w_glyph = w_blank ? GLYPH_BLANK : f_glyph(r_nib[r_idx]);

  // Freeze only gates the output load; the scanner keeps running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= '1;
    end else if (w_tick && !r_freeze) begin
      for (int i = 0; i < 8; i++) begin
        if (r_idx == 3'(i)) r_hex[7*i +: 7] <= w_glyph;
      end
    end
  end

  assign hex_out    = r_hex;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int SD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [55:0] hex_out;
  logic        frame_done;

  always #5 clk = ~clk;

  hex_display_ctrl #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .hex_out    (hex_out),
    .frame_done (frame_done)
  );

  int checks   = 0;
  int failures = 0;
  int fd_seen  = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int         m_nib   [8];
  int         m_en    [8];
  int         m_blink [8];
  int         m_lzs;
  int         m_freeze;
  logic [6:0] m_dig   [8];
  int         m_n;       // rising edges since reset release
  bit         m_fd;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_nib[i] = 0; m_en[i] = 0; m_blink[i] = 0; m_dig[i] = 7'h7F;
    end
    m_lzs = 0; m_freeze = 0; m_n = 0; m_fd = 0;
  endtask

  function automatic logic [55:0] m_hex();
    logic [55:0] v;
    for (int i = 0; i < 8; i++) v[7*i +: 7] = m_dig[i];
    return v;
  endfunction

  function automatic logic [6:0] m_resolve(input int i, input int phase);
    bit lz = 1;
    for (int j = i; j < 8; j++) if (m_en[j] != 0 && m_nib[j] != 0) lz = 0;
    if (m_en[i] == 0) return 7'h7F;
    if (m_blink[i] != 0 && phase != 0) return 7'h7F;
    if (m_lzs != 0 && i != 0 && lz) return 7'h7F;
    return glyph_tab[m_nib[i]];
  endfunction

  // One clock cycle: check outputs at the falling edge, drive inputs, then
  // advance the model across the rising edge.
  task automatic step(input bit we, input logic [3:0] a, input logic [7:0] d);
    int k, idx, f, phase;
    @(negedge clk);
    chk_eq("hex_out", hex_out, m_hex());
    chk_eq("frame_done", frame_done, m_fd);
    if (frame_done === 1'b1) fd_seen++;
    wr_en = we; wr_addr = a; wr_data = d;
    @(posedge clk);
    m_n++;
    m_fd = 0;
    if (m_n % SD == 0) begin
      k     = m_n / SD;
      idx   = (k - 1) % 8;
      f     = (k - 1) / 8;
      phase = (f / BF) % 2;
      if (m_freeze == 0) m_dig[idx] = m_resolve(idx, phase);
      if (idx == 7) m_fd = 1;
    end
    if (we) begin
      if (a < 8) begin
        m_nib[a] = int'(d[3:0]); m_en[a] = int'(d[4]); m_blink[a] = int'(d[5]);
      end else if (a == 8) begin
        m_lzs = int'(d[0]); m_freeze = int'(d[1]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 8'd0);
  endtask

  task automatic chk_dig(input string tag, input int i, input logic [6:0] e);
    chk_eq(tag, 64'(hex_out[7*i +: 7]), 64'(e));
  endtask

  function automatic bit next_is_tick(input int dig);
    return ((m_n + 1) % SD == 0) && ((((m_n + 1) / SD) - 1) % 8 == dig);
  endfunction

  logic [55:0] saved;

  initial begin
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_hex", hex_out, 56'hFF_FFFF_FFFF_FFFF);
    chk_eq("reset_fd", frame_done, 1'b0);
    rst_n = 1'b1;

    // idle after reset: blank digits, frame_done every 32 cycles
    idle(70);

    // glyph sweep, low nibbles
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 8'(8'h10 | i));
    step(1'b1, 4'd0, 8'h1A);
    idle(40);
    #1;
    chk_dig("sweep_d0", 0, 7'b0001000);
    chk_dig("sweep_d3", 3, 7'b0110000);
    chk_dig("sweep_d7", 7, 7'b1111000);

    // glyph sweep, high nibbles
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 8'(8'h18 + i));
    idle(40);
    #1;
    for (int i = 0; i < 8; i++) chk_dig("sweep_hi", i, glyph_tab[8 + i]);

    // leading-zero suppression
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), (i < 4) ? ((i == 2) ? 8'h11 : 8'h10) : 8'h00);
    step(1'b1, 4'd8, 8'h01);
    idle(40);
    #1;
    chk_dig("lzs_d2", 2, 7'b1111001);
    chk_dig("lzs_d1", 1, 7'b1000000);
    chk_dig("lzs_d0", 0, 7'b1000000);
    for (int i = 3; i < 8; i++) chk_dig("lzs_blank", i, 7'b1111111);
    step(1'b1, 4'd8, 8'h00);
    idle(40);
    #1;
    chk_dig("nolzs_d3", 3, 7'b1000000);

    // blink on digit 5
    step(1'b1, 4'd5, 8'h3F);
    idle(200);

    // write/scan collision on digit 2
    step(1'b1, 4'd2, 8'h15);
    idle(40);
    for (int t = 0; t < 64 && !next_is_tick(2); t++) step(1'b0, 4'd0, 8'd0);
    chk_eq("collision_align", 64'(next_is_tick(2)), 64'd1);
    step(1'b1, 4'd2, 8'h1C);
    #1;
    chk_dig("collision_old", 2, 7'b0010010);
    idle(33);
    #1;
    chk_dig("collision_new", 2, 7'b1000110);

    // freeze
    step(1'b1, 4'd8, 8'h02);
    saved = m_hex();
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 8'($urandom_range(0, 63)));
    fd_seen = 0;
    idle(96);
    #1;
    chk_eq("freeze_hold", hex_out, saved);
    chk_eq("freeze_fd_count", 64'(fd_seen), 64'd3);
    step(1'b1, 4'd8, 8'h00);
    idle(40);

    // randomized traffic
    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 3) == 0)
        step(1'b1, 4'($urandom_range(0, 15)), 8'($urandom));
      else
        step(1'b0, 4'($urandom_range(0, 15)), 8'($urandom));
    end

    // mid-operation asynchronous reset
    step(1'b1, 4'd8, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 8'(8'h10 | i));
    idle(38);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("async_rst_hex", hex_out, 56'hFF_FFFF_FFFF_FFFF);
    chk_eq("async_rst_fd", frame_done, 1'b0);
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(40);
    #1;
    chk_eq("post_rst_blank", hex_out, 56'hFF_FFFF_FFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Scanning controller for the board's eight active-low seven-segment digits. A CPU-facing write port loads a small register file: per-digit nibble, enable and blink bits, plus a control register. A prescaled scanner time-shares one hex-to-segment decode path across all eight digit positions. It refreshes one digit output register per scan tick and adds blinking and leading-zero suppression on top of the standard hex glyph table.

## Interface
- SCAN_DIV, 1000: clocks per scan tick (≥2); one digit refreshed per tick.
- BLINK_FRAMES, 64: full 8-digit frames per blink-phase toggle (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe; one write per asserted cycle.
- wr_addr  in  4  0–7 digit register, 8 control register, 9–15 ignored.
- wr_data  in  8  digit: [3:0] nibble, [4] enable, [5] blink. Control: [0] lzs (leading-zero suppress), [1] freeze. Other bits ignored.
- hex_out  out  56  digit i segments at [7i+6:7i], active low, order {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse when a frame completes.

## Operation
- Register file: 8 × {blink, en, nibble}, control {freeze, lzs}. All zero after reset. Writes take effect on the clock edge where wr_en=1.
- Glyphs, active low:
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
  - Blank is 1111111.
- Prescaler counts 0..SCAN_DIV-1 and wraps. The cycle at SCAN_DIV-1 is a scan tick.
- Scanner index idx, 3 bits, reset 0. On each scan tick:
  - If freeze=0, hex_out[digit idx] loads the resolved glyph for digit idx.
  - idx increments, wrapping 7→0.
  - If freeze=1, the hex_out load is skipped, but idx, the prescaler and frame counting continue.
- Resolved glyph for digit i is blank if any of the following holds, otherwise glyph(nibble):
  - en=0;
  - blink=1 and blink_phase=1;
  - lzs=1, i≠0, and every digit j≥i with en=1 has nibble 0.
  - Digits with en=0 do not break the leading-zero run.
- Frame: the scan tick at idx=7. frame_done asserts for the cycle after that tick.
- Blink: a frame counter counts 0..BLINK_FRAMES-1. At wrap, blink_phase (reset 0) toggles.
- Write and scan tick on the same digit in the same cycle: the scan uses the pre-write register contents. The new value appears on that digit's next pass.
- Reset asserted at any time clears everything asynchronously:
  - register file, idx, prescaler, frame counter, blink_phase;
  - hex_out to all ones;
  - frame_done to 0.
- Scanning restarts at digit 0 after release.

## Timing
- Reset values: hex_out = 56'hFF_FFFF_FFFF_FFFF, frame_done = 0.
- First scan tick comes SCAN_DIV cycles after reset release. It updates digit 0 at the end of that cycle.
- A write to digit i is visible on hex_out within 8·SCAN_DIV+1 cycles and never earlier than the next tick with idx=i.
- Control register changes (lzs, freeze) apply from the next scan tick.
- Frame period: 8·SCAN_DIV cycles. Blink half-period: 8·SCAN_DIV·BLINK_FRAMES cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset check (SCAN_DIV=4): hold rst_n=0 → hex_out all ones, frame_done=0. Release with no writes → all digits remain 1111111, and frame_done pulses every 32 cycles.
- Glyph sweep (SCAN_DIV=4): write digit i = {en=1, nibble=i} and digit 0 = 0x1A (nibble A). After one frame:
  - digit0 = 0001000;
  - digit3 = 0110000;
  - digit7 = 1111000.
  - Repeat with nibbles 8–F and check each against the glyph table.
- Leading-zero suppression: digits 0–3 = {en=1, nibble}, digits 7..0 = 0,0,0,0,0,1,0,0, lzs=1 → digit2 shows 1111001, digits 1 and 0 show 1000000, digits 3–7 blank. With lzs=0, digit3 shows 1000000.
- Blink (SCAN_DIV=2, BLINK_FRAMES=2): digit5 = 0x3F (blink, en, F) → digit5 alternates 0001110 / 1111111 every 32 cycles, and the other digits stay steady.
- Write/scan collision and freeze: write digit2 on its tick cycle → old glyph held until the next pass. Set freeze=1 then rewrite all digits → hex_out unchanged over 3 frames while frame_done keeps pulsing. Set freeze=0 → new values appear within 1 frame.
- Mid-operation reset: assert rst_n=0 mid-frame with all digits lit → hex_out goes all ones immediately (asynchronously) and stays blank after release until digits are rewritten.
